control_unit: RTL

Sequencing controller for the `microc` datapath. Decodes the 6-bit opcode returned by the datapath into the control word `s_inc`, `s_inm`, `we3`, `op` plus a PC write enable. Keeps a registered zero flag for conditional jumps and counts retired instructions. Runs a start/halt state machine so that the core executes only after an explicit start.

---
 rtl/control_unit.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// Start/halt sequencer and instruction decoder for the microc datapath.
// Optional feature macro: CONTROL_UNIT_SINGLE_STEP_EN adds a `step` input that gates execution.
module control_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef CONTROL_UNIT_SINGLE_STEP_EN
    input  logic             step,
`endif
    input  logic [5:0]       opcode,
    input  logic             z,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we3,
    output logic [2:0]       op,
    output logic             pc_we,
    output logic             halted,
    output logic             busy,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    typedef struct packed {
        logic       s_inc;
        logic       s_inm;
        logic       we3;
        logic [2:0] op;
        logic       pc_we;
    } ctrl_t;

    localparam logic [5:0] OPC_LI   = 6'b100000;
    localparam logic [5:0] OPC_J    = 6'b110000;
    localparam logic [5:0] OPC_JZ   = 6'b110001;
    localparam logic [5:0] OPC_JNZ  = 6'b110010;
    localparam logic [5:0] OPC_HALT = 6'b111111;

    // Word driven whenever the core must not advance or write anything.
    localparam ctrl_t SAFE_WORD = '{s_inc: 1'b1, s_inm: 1'b0, we3: 1'b0, op: 3'b000, pc_we: 1'b0};

    state_t           state_reg, state_next;
    logic             zf_reg, zf_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             exec_en;
    ctrl_t            dec_word;
    ctrl_t            ctrl_word;
    logic             dec_is_alu;
    logic             dec_is_halt;

`ifdef CONTROL_UNIT_SINGLE_STEP_EN
    assign exec_en = (state_reg == ST_EXEC) && step;
`else
    assign exec_en = (state_reg == ST_EXEC);
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            zf_reg    <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            zf_reg    <= zf_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Instruction decode, independent of state
    always_comb begin
        dec_word    = SAFE_WORD;
        dec_is_alu  = 1'b0;
        dec_is_halt = 1'b0;
        if (!opcode[5]) begin
            dec_is_alu     = 1'b1;
            dec_word.op    = opcode[4:2];
            dec_word.s_inm = 1'b0;
            dec_word.we3   = 1'b1;
            dec_word.s_inc = 1'b1;
            dec_word.pc_we = 1'b1;
        end else begin
            case (opcode)
                OPC_LI: begin
                    dec_word.op    = 3'b000;
                    dec_word.s_inm = 1'b1;
                    dec_word.we3   = 1'b1;
                    dec_word.s_inc = 1'b1;
                    dec_word.pc_we = 1'b1;
                end
                OPC_J: begin
                    dec_word.s_inc = 1'b0;
                    dec_word.pc_we = 1'b1;
                end
                OPC_JZ: begin
                    dec_word.s_inc = ~zf_reg;
                    dec_word.pc_we = 1'b1;
                end
                OPC_JNZ: begin
                    dec_word.s_inc = zf_reg;
                    dec_word.pc_we = 1'b1;
                end
                OPC_HALT: begin
                    dec_is_halt = 1'b1;
                end
                default: begin
                    dec_word.s_inc = 1'b1;
                    dec_word.pc_we = 1'b1;
                end
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_EXEC;
            ST_EXEC: if (exec_en && dec_is_halt) state_next = ST_HALT;
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_IDLE;
        endcase
    end

    // The flag follows only ALU results so JZ/JNZ test the latest ALU op.
    always_comb begin
        zf_next  = zf_reg;
        cnt_next = cnt_reg;
        if (exec_en) begin
            if (dec_is_alu)
                zf_next = z;
            if (cnt_reg != {CNT_W{1'b1}})
                cnt_next = cnt_reg + 1'b1;
        end
    end

    // Output logic; reset forces IDLE asynchronously, so the safe word appears at once.
    always_comb begin
        ctrl_word = SAFE_WORD;
        if (exec_en)
            ctrl_word = dec_word;
    end

    assign s_inc       = ctrl_word.s_inc;
    assign s_inm       = ctrl_word.s_inm;
    assign we3         = ctrl_word.we3;
    assign op          = ctrl_word.op;
    assign pc_we       = ctrl_word.pc_we;
    assign halted      = (state_reg == ST_HALT);
    assign busy        = (state_reg == ST_EXEC);
    assign instr_count = cnt_reg;

endmodule
